// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD bus receiver.
package lcd_pkg;

  // Command opcodes understood by the receiver
  localparam logic [7:0] CMD_CASET  = 8'h2A;
  localparam logic [7:0] CMD_PASET  = 8'h2B;
  localparam logic [7:0] CMD_RAMWR  = 8'h2C;
  localparam logic [7:0] CMD_RAMWRC = 8'h3C;

  // Decode state of the command/data stream
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CASET = 2'd1,
    ST_PASET = 2'd2,
    ST_RAMWR = 2'd3
  } lcd_state_e;

  // Bit positions inside one synchronizer stage word {cs_n, wr_n, rs, d[7:0]}
  localparam int SYNC_W     = 11;
  localparam int SYNC_CS_B  = 10;
  localparam int SYNC_WR_B  = 9;
  localparam int SYNC_RS_B  = 8;
  localparam logic [SYNC_W-1:0] SYNC_IDLE = 11'h600;

endpackage

// File: rtl/lcd_bus_sync.sv
// Input synchronizer for the asynchronous LCD bus plus wr_n/cs_n edge detection.
module lcd_bus_sync
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] lcd_d,
  input  logic       lcd_rs,
  input  logic       lcd_wr_n,
  input  logic       lcd_cs_n,
  output logic [7:0] byte_d,
  output logic       byte_rs,
  output logic       byte_stb,
  output logic       cs_rise
);

  logic [SYNC_STAGES-1:0][SYNC_W-1:0] stage_q, stage_d;
  logic                               wr_prev_q, wr_prev_d;
  logic                               cs_prev_q, cs_prev_d;
  logic [SYNC_W-1:0]                  last_s;

  assign last_s = stage_q[SYNC_STAGES-1];

  // Shift the bus word down the synchronizer chain and remember the last strobe levels
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = {lcd_cs_n, lcd_wr_n, lcd_rs, lcd_d};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    wr_prev_d = last_s[SYNC_WR_B];
    cs_prev_d = last_s[SYNC_CS_B];
  end

  // Synchronizer flops; reset to an idle bus (wr_n=1, cs_n=1)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_q[i] <= SYNC_IDLE;
      end
      wr_prev_q <= 1'b1;
      cs_prev_q <= 1'b1;
    end else begin
      stage_q   <= stage_d;
      wr_prev_q <= wr_prev_d;
      cs_prev_q <= cs_prev_d;
    end
  end

  // A byte is taken on the synchronized wr_n rising edge while cs_n is low
  assign byte_d   = last_s[7:0];
  assign byte_rs  = last_s[SYNC_RS_B];
  assign byte_stb = last_s[SYNC_WR_B] & ~wr_prev_q & ~last_s[SYNC_CS_B];
  assign cs_rise  = last_s[SYNC_CS_B] & ~cs_prev_q;

endmodule

// File: rtl/lcd_bus_rx.sv
// 8080 LCD bus receiver: decodes window commands and streams RGB565 pixels with coordinates.
module lcd_bus_rx
  import lcd_pkg::*;
#(
  parameter int W_COORD     = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         lcd_d,
  input  logic               lcd_rs,
  input  logic               lcd_wr_n,
  input  logic               lcd_cs_n,
  output logic [W_COORD-1:0] px_x,
  output logic [W_COORD-1:0] px_y,
  output logic [15:0]        px_data,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [7:0]         cmd_byte,
  output logic               cmd_stb,
  output logic               err_ovf
);

  logic [7:0] byte_d_s;
  logic       byte_rs_s, byte_stb_s, cs_rise_s;

  lcd_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .lcd_d    (lcd_d),
    .lcd_rs   (lcd_rs),
    .lcd_wr_n (lcd_wr_n),
    .lcd_cs_n (lcd_cs_n),
    .byte_d   (byte_d_s),
    .byte_rs  (byte_rs_s),
    .byte_stb (byte_stb_s),
    .cs_rise  (cs_rise_s)
  );

  lcd_state_e         state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;          // CASET/PASET parameter bytes seen (saturates at 4)
  logic [23:0]        buf_q, buf_d;          // first three parameter bytes
  logic               half_q, half_d;        // high pixel byte pending
  logic [7:0]         hi_q, hi_d;
  logic [W_COORD-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [W_COORD-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [W_COORD-1:0] px_x_q, px_x_d, px_y_q, px_y_d;
  logic [15:0]        px_data_q, px_data_d;
  logic               px_valid_q, px_valid_d;
  logic [7:0]         cmd_byte_q, cmd_byte_d;
  logic               cmd_stb_q, cmd_stb_d;
  logic               err_q, err_d;
  logic               pix_done_s;
  logic [15:0]        start_s, end_s;

  assign start_s = {buf_q[23:16], buf_q[15:8]};
  assign end_s   = {buf_q[7:0], byte_d_s};

  // Command decode, parameter collection, pixel assembly, output handshake and cursor walk
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    half_d     = half_q;
    hi_d       = hi_q;
    xs_d       = xs_q;
    xe_d       = xe_q;
    ys_d       = ys_q;
    ye_d       = ye_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    px_x_d     = px_x_q;
    px_y_d     = px_y_q;
    px_data_d  = px_data_q;
    cmd_byte_d = cmd_byte_q;
    cmd_stb_d  = 1'b0;
    err_d      = err_q;
    pix_done_s = 1'b0;

    if (px_valid_q && px_ready) begin
      px_valid_d = 1'b0;
    end else begin
      px_valid_d = px_valid_q;
    end

    if (cs_rise_s) begin
      // Deselect abandons any half-received pixel or parameter list
      half_d = 1'b0;
      cnt_d  = 3'd0;
    end else if (byte_stb_s) begin
      if (!byte_rs_s) begin
        cmd_stb_d  = 1'b1;
        cmd_byte_d = byte_d_s;
        half_d     = 1'b0;
        cnt_d      = 3'd0;
        case (byte_d_s)
          CMD_CASET:  state_d = ST_CASET;
          CMD_PASET:  state_d = ST_PASET;
          CMD_RAMWR: begin
            state_d = ST_RAMWR;
            cx_d    = xs_q;
            cy_d    = ys_q;
          end
          CMD_RAMWRC: state_d = ST_RAMWR;
          default:    state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_PASET: begin
            if (cnt_q < 3'd3) begin
              buf_d = {buf_q[15:0], byte_d_s};
              cnt_d = cnt_q + 3'd1;
            end else if (cnt_q == 3'd3) begin
              cnt_d = 3'd4;
              if (state_q == ST_CASET) begin
                xs_d = start_s[W_COORD-1:0];
                xe_d = end_s[W_COORD-1:0];
              end else begin
                ys_d = start_s[W_COORD-1:0];
                ye_d = end_s[W_COORD-1:0];
              end
            end else begin
              cnt_d = cnt_q;
            end
          end
          ST_RAMWR: begin
            if (!half_q) begin
              hi_d   = byte_d_s;
              half_d = 1'b1;
            end else begin
              half_d     = 1'b0;
              pix_done_s = 1'b1;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end

    if (pix_done_s) begin
      if (!px_valid_q || px_ready) begin
        px_valid_d = 1'b1;
        px_x_d     = cx_q;
        px_y_d     = cy_q;
        px_data_d  = {hi_q, byte_d_s};
      end else begin
        err_d = 1'b1;
      end
      if (cx_q == xe_q) begin
        cx_d = xs_q;
        if (cy_q == ye_q) begin
          cy_d = ys_q;
        end else begin
          cy_d = cy_q + W_COORD'(1);
        end
      end else begin
        cx_d = cx_q + W_COORD'(1);
      end
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 3'd0;
      buf_q      <= 24'd0;
      half_q     <= 1'b0;
      hi_q       <= 8'd0;
      xs_q       <= {W_COORD{1'b0}};
      xe_q       <= {W_COORD{1'b1}};
      ys_q       <= {W_COORD{1'b0}};
      ye_q       <= {W_COORD{1'b1}};
      cx_q       <= {W_COORD{1'b0}};
      cy_q       <= {W_COORD{1'b0}};
      px_x_q     <= {W_COORD{1'b0}};
      px_y_q     <= {W_COORD{1'b0}};
      px_data_q  <= 16'd0;
      px_valid_q <= 1'b0;
      cmd_byte_q <= 8'd0;
      cmd_stb_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      half_q     <= half_d;
      hi_q       <= hi_d;
      xs_q       <= xs_d;
      xe_q       <= xe_d;
      ys_q       <= ys_d;
      ye_q       <= ye_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      px_x_q     <= px_x_d;
      px_y_q     <= px_y_d;
      px_data_q  <= px_data_d;
      px_valid_q <= px_valid_d;
      cmd_byte_q <= cmd_byte_d;
      cmd_stb_q  <= cmd_stb_d;
      err_q      <= err_d;
    end
  end

  assign px_x     = px_x_q;
  assign px_y     = px_y_q;
  assign px_data  = px_data_q;
  assign px_valid = px_valid_q;
  assign cmd_byte = cmd_byte_q;
  assign cmd_stb  = cmd_stb_q;
  assign err_ovf  = err_q;

endmodule

// File: tb/tb_lcd_bus_rx.sv
// Self-checking bench for lcd_bus_rx: table-driven byte stream plus scoreboarded outputs.
module tb_lcd_bus_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] lcd_d;
  logic       lcd_rs, lcd_wr_n, lcd_cs_n;
  logic [8:0] px_x, px_y;
  logic [15:0] px_data;
  logic       px_valid, px_ready;
  logic [7:0] cmd_byte;
  logic       cmd_stb, err_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } px_t;

  typedef struct {
    logic        rs;
    logic [7:0]  d;
    logic        push;
    logic [8:0]  x;
    logic [8:0]  y;
    logic [15:0] pix;
  } vec_t;

  px_t        px_q[$];
  logic [7:0] cmd_q[$];
  vec_t       tbl[$];

  int xa[7] = '{10, 11, 12, 10, 11, 12, 10};
  int ya[7] = '{5, 5, 5, 6, 6, 6, 5};

  always #5 clk = ~clk;

  lcd_bus_rx #(.W_COORD(9), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lcd_d    (lcd_d),
    .lcd_rs   (lcd_rs),
    .lcd_wr_n (lcd_wr_n),
    .lcd_cs_n (lcd_cs_n),
    .px_x     (px_x),
    .px_y     (px_y),
    .px_data  (px_data),
    .px_valid (px_valid),
    .px_ready (px_ready),
    .cmd_byte (cmd_byte),
    .cmd_stb  (cmd_stb),
    .err_ovf  (err_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus write; command bytes with chip select active are expected on cmd_stb
  task automatic send(input logic rs, input logic [7:0] d, input logic cs);
    if (!rs && !cs) cmd_q.push_back(d);
    lcd_cs_n = cs;
    lcd_rs   = rs;
    lcd_d    = d;
    cyc(2);
    lcd_wr_n = 1'b0;
    cyc(4);
    lcd_wr_n = 1'b1;
    cyc(6);
  endtask

  task automatic exp_px(input int x, input int y, input logic [15:0] d);
    px_t p;
    p.x = 9'(x);
    p.y = 9'(y);
    p.d = d;
    px_q.push_back(p);
  endtask

  task automatic send_px(input logic [15:0] d);
    send(1'b1, d[15:8], 1'b0);
    send(1'b1, d[7:0], 1'b0);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 100 && (px_q.size() != 0 || cmd_q.size() != 0); i++) @(negedge clk);
    checks++;
    if (px_q.size() != 0 || cmd_q.size() != 0) begin
      errors++;
      $display("FAIL %s: outstanding pixels %0d commands %0d, required 0 0", name, px_q.size(), cmd_q.size());
      px_q.delete();
      cmd_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_px_valid"}, 32'(px_valid), 32'd0);
    chk({tag, "_cmd_stb"},  32'(cmd_stb),  32'd0);
    chk({tag, "_err_ovf"},  32'(err_ovf),  32'd0);
    chk({tag, "_px_x"},     32'(px_x),     32'd0);
    chk({tag, "_px_y"},     32'(px_y),     32'd0);
    chk({tag, "_px_data"},  32'(px_data),  32'd0);
    chk({tag, "_cmd_byte"}, 32'(cmd_byte), 32'd0);
  endtask

  function automatic void add(input logic rs, input logic [7:0] d, input logic push,
                              input int x, input int y, input logic [15:0] pix);
    vec_t v;
    v.rs = rs; v.d = d; v.push = push; v.x = 9'(x); v.y = 9'(y); v.pix = pix;
    tbl.push_back(v);
  endfunction

  // Output scoreboard: every transfer and every command strobe must match the next expectation
  always @(negedge clk) begin
    if (rst_n && px_valid && px_ready) begin
      if (px_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel: got (%0d,%0d)=%0h required none", px_x, px_y, px_data);
      end else begin
        px_t e;
        e = px_q.pop_front();
        chk("px_x", 32'(px_x), 32'(e.x));
        chk("px_y", 32'(px_y), 32'(e.y));
        chk("px_data", 32'(px_data), 32'(e.d));
      end
    end
    if (rst_n && cmd_stb) begin
      if (cmd_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cmd_stb: got %0h required none", cmd_byte);
      end else begin
        chk("cmd_byte", 32'(cmd_byte), 32'(cmd_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    lcd_d    = 8'h00;
    lcd_rs   = 1'b1;
    lcd_wr_n = 1'b1;
    lcd_cs_n = 1'b1;
    px_ready = 1'b1;
    cyc(4);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    cyc(2);

    // Window 10..12 x 5..6, then seven pixels including the wrap back to the origin
    add(1'b0, 8'h2A, 1'b0, 0, 0, 16'h0);
    add(1'b1, 8'h00, 1'b0, 0, 0, 16'h0);
    add(1'b1, 8'h0A, 1'b0, 0, 0, 16'h0);
    add(1'b1, 8'h00, 1'b0, 0, 0, 16'h0);
    add(1'b1, 8'h0C, 1'b0, 0, 0, 16'h0);
    add(1'b0, 8'h2B, 1'b0, 0, 0, 16'h0);
    add(1'b1, 8'h00, 1'b0, 0, 0, 16'h0);
    add(1'b1, 8'h05, 1'b0, 0, 0, 16'h0);
    add(1'b1, 8'h00, 1'b0, 0, 0, 16'h0);
    add(1'b1, 8'h06, 1'b0, 0, 0, 16'h0);
    add(1'b0, 8'h2C, 1'b0, 0, 0, 16'h0);
    for (int i = 0; i < 7; i++) begin
      add(1'b1, 8'h12, 1'b0, 0, 0, 16'h0);
      add(1'b1, 8'(8'h34 + i), 1'b1, xa[i], ya[i], 16'h1234 + 16'(i));
    end
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].push) exp_px(int'(tbl[i].x), int'(tbl[i].y), tbl[i].pix);
      send(tbl[i].rs, tbl[i].d, 1'b0);
    end
    drain("window_walk");

    // Back-pressure: first pixel held, next two dropped, cursor still advances
    px_ready = 1'b0;
    exp_px(11, 5, 16'h5A01);
    send_px(16'h5A01);
    send_px(16'h5A02);
    send_px(16'h5A03);
    cyc(2);
    chk("hold_valid", 32'(px_valid), 32'd1);
    chk("hold_x", 32'(px_x), 32'd11);
    chk("hold_y", 32'(px_y), 32'd5);
    chk("hold_data", 32'(px_data), 32'h5A01);
    chk("ovf_set", 32'(err_ovf), 32'd1);
    px_ready = 1'b1;
    drain("held_release");
    send(1'b0, 8'h3C, 1'b0);
    exp_px(11, 6, 16'h7777);
    send_px(16'h7777);
    drain("continue_after_drop");
    chk("ovf_sticky", 32'(err_ovf), 32'd1);

    // Half pixel discarded by deselect, then restarted with 0x2C
    send(1'b1, 8'hAB, 1'b0);
    lcd_cs_n = 1'b1;
    cyc(6);
    send(1'b0, 8'h2C, 1'b0);
    exp_px(10, 5, 16'hCDEF);
    send_px(16'hCDEF);
    drain("cs_discard_cmd");

    // Half pixel discarded by deselect alone, RAMWR continues
    send(1'b1, 8'hAB, 1'b0);
    lcd_cs_n = 1'b1;
    cyc(6);
    exp_px(11, 5, 16'h1234);
    send_px(16'h1234);
    drain("cs_discard_only");

    // Strobes with cs_n high are ignored; unknown command returns to idle
    send(1'b1, 8'h55, 1'b1);
    send(1'b1, 8'h66, 1'b1);
    send(1'b0, 8'h99, 1'b1);
    send(1'b0, 8'h99, 1'b0);
    send_px(16'h1122);
    drain("unknown_cmd");
    chk("idle_no_pixel", 32'(px_valid), 32'd0);

    // Reset between the bytes of a pixel
    send(1'b0, 8'h2C, 1'b0);
    exp_px(10, 5, 16'h4242);
    send_px(16'h4242);
    drain("pre_reset_pixel");
    send(1'b1, 8'h44, 1'b0);
    rst_n = 1'b0;
    cyc(3);
    chk_reset_outputs("midreset");
    rst_n = 1'b1;
    cyc(2);
    send_px(16'h5566);
    drain("post_reset_ignored");
    send(1'b0, 8'h2C, 1'b0);
    exp_px(0, 0, 16'h5566);
    send_px(16'h5566);
    drain("post_reset_origin");

    // High coordinate byte survives truncation to 9 bits: xs = 0x140
    send(1'b0, 8'h2A, 1'b0);
    send(1'b1, 8'h01, 1'b0);
    send(1'b1, 8'h40, 1'b0);
    send(1'b1, 8'h00, 1'b0);
    send(1'b1, 8'h00, 1'b0);
    send(1'b0, 8'h2C, 1'b0);
    exp_px(320, 0, 16'hABCD);
    exp_px(321, 0, 16'h1111);
    send_px(16'hABCD);
    send_px(16'h1111);
    drain("wide_xs");

    cyc(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
